// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the level-reporting sync FIFO: sizing, default thresholds and
// parameter legality.
package sync_fifo_pkg;

  localparam int unsigned DefaultWidth    = 8;
  localparam int unsigned DefaultDepth    = 16;
  localparam int unsigned DefaultAeThresh = 2;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // One extra bit so full and empty are distinguishable from the pointers alone.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return addr_width(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int unsigned width,
                                      input int unsigned depth,
                                      input int unsigned af_thresh,
                                      input int unsigned ae_thresh);
    return (width >= 1) && (depth >= 2) && is_pow2(depth) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// One-write/one-read register array; RD_REG picks a registered or combinational
// read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter bit          RD_REG = 1'b1,
  localparam int unsigned AW    = addr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Storage is deliberately not reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (RD_REG) begin : gen_rd_reg
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdata_q <= '0;
      end else if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end

    assign rdata_o = rdata_q;
  end else begin : gen_rd_comb
    logic unused_rd_ctrl;

    assign rdata_o        = mem_q[raddr_i];
    assign unused_rd_ctrl = rst_i ^ re_i;
  end

endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_level
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter bit          FWFT      = 1'b0,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = DefaultAeThresh,
  localparam int unsigned AW       = addr_width(DEPTH),
  localparam int unsigned CW       = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             clr_err_i
);

  if (!params_legal(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : gen_param_err
    $error("sync_fifo_level: illegal WIDTH/DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          full, empty;
  logic          wr_accept, rd_accept;

  // Flags decode from the registered count only, so acceptance never depends on
  // the opposite port's activity in the same cycle.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_accept = wr_en_i & ~full;
  assign rd_accept = rd_en_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  // A new error event wins over a clear in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en_i && full) begin
      overflow_d = 1'b1;
    end
    if (rd_en_i && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RD_REG (!FWFT)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data_i),
    .re_i    (rd_accept),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data_o)
  );

  if (FWFT) begin : gen_valid_fwft
    assign rd_valid_o = ~empty;
  end else begin : gen_valid_reg
    logic rd_valid_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
      end
    end

    assign rd_valid_o = rd_valid_q;
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= CW'(AF_THRESH));
  assign almost_empty_o = (count_q <= CW'(AE_THRESH));
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  assert property (@(posedge clk_i) disable iff (rst_i) count_q <= CW'(DEPTH))
    else $error("sync_fifo_level: occupancy exceeds DEPTH");

endmodule

// File: tb/tb_sync_fifo_level.sv
// Self-checking bench for sync_fifo_level: registered-read instance driven by a
// reference queue model plus a vector table, and a fall-through instance.
module tb_sync_fifo_level;

  localparam int unsigned Depth = 16;
  localparam int unsigned AfTh  = 14;
  localparam int unsigned AeTh  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  // Registered-read instance
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, afull, aempty, ovf, udf;
  logic [4:0] count;

  // Fall-through instance
  logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
  logic [7:0] f_wr_data = '0;
  logic [7:0] f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0] f_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_q [$];
  logic [7:0] exp_q [$];
  logic       m_ovf = 1'b0, m_udf = 1'b0;
  logic [7:0] last_data = '0;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic [4:0] exp_count;
    logic       exp_ovf;
    logic       exp_udf;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  sync_fifo_level #(
    .WIDTH(8), .DEPTH(Depth), .FWFT(1'b0), .AF_THRESH(AfTh), .AE_THRESH(AeTh)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_en_i(rd_en),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .full_o(full), .empty_o(empty),
    .almost_full_o(afull), .almost_empty_o(aempty), .count_o(count),
    .overflow_o(ovf), .underflow_o(udf), .clr_err_i(clr_err)
  );

  sync_fifo_level #(
    .WIDTH(8), .DEPTH(Depth), .FWFT(1'b1), .AF_THRESH(AfTh), .AE_THRESH(AeTh)
  ) dut_f (
    .clk_i(clk), .rst_i(rst), .wr_en_i(f_wr_en), .wr_data_i(f_wr_data), .rd_en_i(f_rd_en),
    .rd_data_o(f_rd_data), .rd_valid_o(f_rd_valid), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_afull), .almost_empty_o(f_aempty), .count_o(f_count),
    .overflow_o(f_ovf), .underflow_o(f_udf), .clr_err_i(f_clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output of the registered instance against the model.
  task automatic check_state(input logic exp_valid);
    int unsigned sz;
    sz = model_q.size();
    check("count", 32'(count), 32'(sz));
    check("full", 32'(full), 32'(sz == Depth));
    check("empty", 32'(empty), 32'(sz == 0));
    check("almost_full", 32'(afull), 32'(sz >= AfTh));
    check("almost_empty", 32'(aempty), 32'(sz <= AeTh));
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("underflow", 32'(udf), 32'(m_udf));
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: rd_valid with data 0x%0h, expected no output", rd_data);
      end else begin
        last_data = exp_q.pop_front();
      end
    end
    check("rd_data", 32'(rd_data), 32'(last_data));
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    logic wr_ok, rd_ok;
    wr_ok = wr && (model_q.size() < Depth);
    rd_ok = rd && (model_q.size() > 0);
    if (clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (wr && !wr_ok) m_ovf = 1'b1;
    if (rd && !rd_ok) m_udf = 1'b1;
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    check_state(rd_ok);
  endtask

  task automatic apply_vec(input int i);
    step(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].clr);
    check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
    check($sformatf("vec%0d overflow", i), 32'(ovf), 32'(vecs[i].exp_ovf));
    check($sformatf("vec%0d underflow", i), 32'(udf), 32'(vecs[i].exp_udf));
    check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
    check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
  endtask

  // Reset both instances, optionally with a write pending on the registered one.
  task automatic do_reset(input logic wr_during);
    rst = 1'b1; wr_en = wr_during; wr_data = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0;
    model_q.delete(); exp_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; last_data = '0;
    check("rst count", 32'(count), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst almost_empty", 32'(aempty), 32'd1);
    check("rst full", 32'(full), 32'd0);
    check("rst almost_full", 32'(afull), 32'd0);
    check("rst rd_valid", 32'(rd_valid), 32'd0);
    check("rst rd_data", 32'(rd_data), 32'd0);
    check("rst overflow", 32'(ovf), 32'd0);
    check("rst underflow", 32'(udf), 32'd0);
    check("rst fwft count", 32'(f_count), 32'd0);
    check("rst fwft empty", 32'(f_empty), 32'd1);
    check("rst fwft rd_valid", 32'(f_rd_valid), 32'd0);
  endtask

  task automatic f_step(input logic wr, input logic [7:0] d, input logic rd);
    f_wr_en = wr; f_wr_data = d; f_rd_en = rd;
    @(posedge clk);
    #1;
    f_wr_en = 1'b0; f_rd_en = 1'b0;
  endtask

  initial begin
    //          wr    data   rd    clr   cnt    ovf   udf   vld   data
    vecs[0]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'hBB, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 1'b1, 8'h01};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0, 8'h01};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 8'h10};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 8'h10};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 8'h10};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 8'h10};
    vecs[10] = '{1'b1, 8'h77, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1, 1'b0, 8'h10};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1,  1'b0, 1'b0, 1'b0, 8'h10};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 8'h77};

    @(posedge clk);
    #1;
    do_reset(1'b0);

    // Fill to full, then overflow and sticky-clear vectors.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("filled full", 32'(full), 32'd1);
    for (int i = 0; i <= 5; i++) apply_vec(i);

    // Drain the remaining 15 words in order.
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drained empty", 32'(empty), 32'd1);
    for (int i = 6; i <= 12; i++) apply_vec(i);

    // Steady count 8 with simultaneous read and write; pointers wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
    check("steady count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Fall-through: data visible without a read request.
    f_step(1'b1, 8'h5A, 1'b0);
    check("fwft data", 32'(f_rd_data), 32'h5A);
    check("fwft valid", 32'(f_rd_valid), 32'd1);
    check("fwft count", 32'(f_count), 32'd1);
    f_step(1'b1, 8'h3C, 1'b1);
    check("fwft next data", 32'(f_rd_data), 32'h3C);
    check("fwft count pair", 32'(f_count), 32'd1);
    f_step(1'b0, 8'h00, 1'b1);
    check("fwft empty", 32'(f_empty), 32'd1);
    check("fwft valid low", 32'(f_rd_valid), 32'd0);
    f_step(1'b0, 8'h00, 1'b1);
    check("fwft underflow", 32'(f_udf), 32'd1);

    // Reset at count 9 mid-stream discards contents.
    for (int i = 0; i < 9; i++) step(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
    f_step(1'b1, 8'h11, 1'b0);
    f_step(1'b1, 8'h22, 1'b0);
    check("pre-reset count", 32'(count), 32'd9);
    do_reset(1'b1);
    check("rst fwft underflow", 32'(f_udf), 32'd0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b1, 8'hD4, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post-reset data", 32'(rd_data), 32'hC3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    f_step(1'b1, 8'h99, 1'b0);
    check("post-reset fwft data", 32'(f_rd_data), 32'h99);
    check("post-reset fwft count", 32'(f_count), 32'd1);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
